bit_decoder: RTL

BIT_DECODER -- requirements
Module: bit_decoder

---
 rtl/dcc_pkg.sv | 30 +++
 rtl/dcc_sync_edge.sv | 42 ++++
 rtl/bit_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dcc_pkg.sv
// Shared types and constants for the DCC bit decoder.
// The phase classifier is kept here so the unit-based timing windows live in one place.
package dcc_pkg;

  // Matches the encoder's prescaler period in clk cycles per half-bit unit.
  localparam int unsigned DefaultUnitCycles = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } dcc_state_e;

  typedef enum logic [1:0] {
    ClsShort,
    ClsLong,
    ClsInvalid
  } phase_class_e;

  // Short: [unit/2, 3*unit/2-1], long: [3*unit/2, 5*unit/2], anything else invalid.
  function automatic phase_class_e classify(input int unsigned len, input int unsigned unit);
    if (len >= unit / 2 && len <= (3 * unit) / 2 - 1) begin
      return ClsShort;
    end else if (len >= (3 * unit) / 2 && len <= (5 * unit) / 2) begin
      return ClsLong;
    end
    return ClsInvalid;
  endfunction

endpackage

// File: rtl/dcc_sync_edge.sv
// Two-flop synchronizer for the DCC line plus registered rise/fall strobes.
// Edges are suppressed until a genuine high level has passed through the synchronizer.
module dcc_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync2_q;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       rise_q, fall_q;

  // fill_q tracks when sync2_q carries real line data rather than reset values,
  // so a line held low through reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & sync2_q);
      rise_q  <= armed_q & ~prev_q & sync2_q;
      fall_q  <= armed_q & prev_q & ~sync2_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/bit_decoder.sv
// DCC bit decoder: measures low/high phase lengths and emits one decoded bit per
// low+high pair, or an error strobe on any timing violation.
module bit_decoder
  import dcc_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = DefaultUnitCycles,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic encoded_in,
  output logic bit_out,
  output logic bit_valid,
  output logic err
);

  localparam int unsigned LongMax = (5 * UNIT_CYCLES) / 2;
  localparam logic [CNT_W-1:0] CntSat = CNT_W'(LongMax + 1);

  logic rise, fall;

  dcc_sync_edge u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (encoded_in),
    .rise     (rise),
    .fall     (fall)
  );

  dcc_state_e   state_q, state_d;
  phase_class_e low_cls_q, low_cls_d;
  phase_class_e cur_cls;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      low_cls_q   <= ClsShort;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_cls_q   <= low_cls_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      err_q       <= err_d;
    end
  end

  // cnt_q equals the length of the phase that an edge on this cycle terminates.
  assign cur_cls = classify(32'(cnt_q), UNIT_CYCLES);

  always_comb begin
    state_d     = state_q;
    low_cls_d   = low_cls_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    err_d       = 1'b0;

    if (rise || fall) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StLow;
        end
      end
      StLow: begin
        if (rise) begin
          if (cur_cls == ClsInvalid) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            low_cls_d = cur_cls;
            state_d   = StHigh;
          end
        end else if (cnt_q == CntSat) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StHigh: begin
        // The fall that closes this bit also opens the next one.
        if (fall) begin
          state_d = StLow;
          if (low_cls_q == ClsShort && cur_cls == ClsShort) begin
            bit_out_d   = 1'b1;
            bit_valid_d = 1'b1;
          end else if (low_cls_q == ClsLong && cur_cls == ClsLong) begin
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == CntSat) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign err       = err_q;

endmodule
